// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-pin bundle for sram_port_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM device.
interface sram_port_arbiter_if;
    logic        i_wr_req;
    logic [19:0] i_wr_addr;
    logic [15:0] i_wr_data;
    logic        o_wr_ack;
    logic        i_rd_req;
    logic [19:0] i_rd_addr;
    logic [15:0] o_rd_data;
    logic        o_rd_valid;
    logic [19:0] o_SRAM_ADDR;
    logic [15:0] i_SRAM_DQ;
    logic [15:0] o_SRAM_DQ;
    logic        o_SRAM_DQ_oe;
    logic        o_SRAM_WE_N;
    logic        o_SRAM_OE_N;
    logic        o_SRAM_CE_N;
    logic        o_busy;

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_SRAM_DQ,
        output o_wr_ack, o_rd_data, o_rd_valid, o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_oe,
               o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_CE_N, o_busy
    );

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_SRAM_DQ,
        input  o_wr_ack, o_rd_data, o_rd_valid, o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_oe,
               o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_CE_N, o_busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port (writer/reader) arbiter driving an asynchronous SRAM with fully registered strobes.
// Define SRAM_ARB_RR_EN to alternate ties between requesters; otherwise the reader always wins ties.
module sram_port_arbiter #(
    parameter int unsigned WR_PULSE_CYC = 1
) (
    input  logic                  i_bclk,
    input  logic                  i_rst,
    sram_port_arbiter_if.slave    io_bus
);

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR, RD_SAMPLE
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE_CYC - 1);

    state_t      r_state;
    logic [3:0]  r_pulse_cnt;
    logic        r_wr_pend;
    logic [19:0] r_addr;
    logic [15:0] r_dq;
    logic        r_dq_oe;
    logic        r_we_n;
    logic        r_oe_n;
    logic        r_ce_n;
    logic        r_wr_ack;
    logic        r_rd_valid;
    logic [15:0] r_rd_data;
    logic        r_busy;

    logic        w_wr_req;
    logic        w_grant_rd;

    // A writer still requesting in its ack cycle is remembered so the request survives WR_HOLD.
    assign w_wr_req = io_bus.i_wr_req | r_wr_pend;

`ifdef SRAM_ARB_RR_EN
    logic r_last_rd;
    assign w_grant_rd = io_bus.i_rd_req & (~w_wr_req | ~r_last_rd);
`else
    assign w_grant_rd = io_bus.i_rd_req;
`endif

    // NOTE: every register here uses <= so all branches see the pre-edge values.
    always_ff @(posedge i_bclk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_pulse_cnt <= '0;
            r_wr_pend   <= 1'b0;
            r_addr      <= '0;
            r_dq        <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_ce_n      <= 1'b1;
            r_wr_ack    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_busy      <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            r_last_rd   <= 1'b1;
`endif
        end else begin
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_rd) begin
                        r_state <= RD_ADDR;
                        r_addr  <= io_bus.i_rd_addr;
                        r_ce_n  <= 1'b0;
                        r_oe_n  <= 1'b0;
                        r_dq_oe <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef SRAM_ARB_RR_EN
                        r_last_rd <= 1'b1;
`endif
                    end else if (w_wr_req) begin
                        r_state   <= WR_SETUP;
                        r_addr    <= io_bus.i_wr_addr;
                        r_dq      <= io_bus.i_wr_data;
                        r_ce_n    <= 1'b0;
                        r_dq_oe   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_wr_pend <= 1'b0;
`ifdef SRAM_ARB_RR_EN
                        r_last_rd <= 1'b0;
`endif
                    end
                end
                WR_SETUP: begin
                    r_state     <= WR_PULSE;
                    r_we_n      <= 1'b0;
                    r_pulse_cnt <= PULSE_LAST;
                end
                WR_PULSE: begin
                    if (r_pulse_cnt == 4'd0) begin
                        r_state  <= WR_HOLD;
                        r_we_n   <= 1'b1;
                        r_wr_ack <= 1'b1;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    r_state   <= IDLE;
                    r_ce_n    <= 1'b1;
                    r_dq_oe   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_wr_pend <= io_bus.i_wr_req;
                end
                RD_ADDR: begin
                    r_state <= RD_SAMPLE;
                end
                RD_SAMPLE: begin
                    r_state    <= IDLE;
                    r_rd_data  <= io_bus.i_SRAM_DQ;
                    r_rd_valid <= 1'b1;
                    r_ce_n     <= 1'b1;
                    r_oe_n     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.o_wr_ack     = r_wr_ack;
    assign io_bus.o_rd_valid   = r_rd_valid;
    assign io_bus.o_rd_data    = r_rd_data;
    assign io_bus.o_SRAM_ADDR  = r_addr;
    assign io_bus.o_SRAM_DQ    = r_dq;
    assign io_bus.o_SRAM_DQ_oe = r_dq_oe;
    assign io_bus.o_SRAM_WE_N  = r_we_n;
    assign io_bus.o_SRAM_OE_N  = r_oe_n;
    assign io_bus.o_SRAM_CE_N  = r_ce_n;
    assign io_bus.o_busy       = r_busy;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed cases plus random requesters against
// a transaction-latency reference model and a 64-word SRAM model.
module tb_sram_port_arbiter;

    localparam int P = 1;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam byte CH_R = 8'h52;
    localparam byte CH_W = 8'h57;

    logic bclk  = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(.WR_PULSE_CYC(P)) dut (
        .i_bclk (bclk),
        .i_rst  (rst_n),
        .io_bus (bus)
    );

    always #5 bclk = ~bclk;

    logic [15:0] sram    [64];
    logic [15:0] ref_mem [64];
    bit          mem_init = 1'b0;

    assign bus.i_SRAM_DQ = (!bus.o_SRAM_OE_N && !bus.o_SRAM_CE_N) ? sram[bus.o_SRAM_ADDR[5:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: one operation at a time, timed from its grant cycle.
    int          cyc = 0, free_at = 0, g_cyc = 0, rel = 0;
    int          wr_grants = 0, rd_grants = 0;
    bit          has_op = 1'b0, op_wr = 1'b0, last_rd = 1'b1, wr_pend = 1'b0;
    bit          busy_e, ack_e, val_e, we_e, wr_eff, take_rd;
    logic [19:0] g_addr = '0;
    logic [15:0] g_data = '0, exp_rd = '0;
    byte         obs_q[$];

    always @(negedge bclk) begin
        if (!rst_n) begin
            if (!mem_init) begin
                for (int i = 0; i < 64; i++) begin
                    sram[i]    = 16'($urandom);
                    ref_mem[i] = sram[i];
                end
                mem_init = 1'b1;
            end
            has_op  = 1'b0;
            free_at = 0;
            wr_pend = 1'b0;
            last_rd = 1'b1;
        end else begin
            cyc++;
            rel    = cyc - g_cyc;
            busy_e = cyc < free_at;
            ack_e  = has_op && op_wr && rel == 2 + P;
            val_e  = has_op && !op_wr && rel == 3;
            we_e   = has_op && op_wr && rel >= 2 && rel <= 1 + P;
            check("busy", bus.o_busy, busy_e);
            check("wr_ack", bus.o_wr_ack, ack_e);
            check("rd_valid", bus.o_rd_valid, val_e);
            check("we_n", bus.o_SRAM_WE_N, !we_e);
            check("dq_oe_vs_oe_n", bus.o_SRAM_DQ_oe & ~bus.o_SRAM_OE_N, 1'b0);
            if (!busy_e) begin
                check("ce_n_idle", bus.o_SRAM_CE_N, 1'b1);
            end else begin
                check("addr", bus.o_SRAM_ADDR, g_addr);
                if (op_wr) begin
                    check("dq_oe_wr", bus.o_SRAM_DQ_oe, 1'b1);
                    check("dq_wr", bus.o_SRAM_DQ, g_data);
                end else begin
                    check("oe_n_rd", bus.o_SRAM_OE_N, 1'b0);
                end
            end
            if (val_e) check("rd_data", bus.o_rd_data, exp_rd);
            if (!bus.o_SRAM_CE_N && !bus.o_SRAM_WE_N) sram[bus.o_SRAM_ADDR[5:0]] = bus.o_SRAM_DQ;
            if (bus.o_wr_ack) obs_q.push_back(CH_W);
            if (bus.o_rd_valid) obs_q.push_back(CH_R);
            if (ack_e && bus.i_wr_req) wr_pend = 1'b1;
            if (!busy_e) begin
                wr_eff  = bus.i_wr_req || wr_pend;
                take_rd = bus.i_rd_req && (!wr_eff || !RR || !last_rd);
                if (take_rd) begin
                    has_op = 1'b1; op_wr = 1'b0; g_cyc = cyc;
                    g_addr = bus.i_rd_addr;
                    exp_rd = ref_mem[g_addr[5:0]];
                    free_at = cyc + 3;
                    last_rd = 1'b1;
                    rd_grants++;
                end else if (wr_eff) begin
                    has_op = 1'b1; op_wr = 1'b1; g_cyc = cyc;
                    g_addr = bus.i_wr_addr;
                    g_data = bus.i_wr_data;
                    ref_mem[g_addr[5:0]] = g_data;
                    free_at = cyc + 3 + P;
                    wr_pend = 1'b0;
                    last_rd = 1'b0;
                    wr_grants++;
                end
            end
        end
    end

    int wr_seen = 0, rd_seen = 0;

    task automatic agent_step();
        if (bus.i_wr_req) begin
            if (wr_grants != wr_seen && $urandom_range(0, 1) == 1) begin
                bus.i_wr_req  = 1'b0;
                bus.i_wr_addr = 20'($urandom);
                wr_seen = wr_grants;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            bus.i_wr_req  = 1'b1;
            bus.i_wr_addr = 20'($urandom);
            bus.i_wr_data = 16'($urandom);
            wr_seen = wr_grants;
        end
        if (bus.i_rd_req) begin
            if (rd_grants != rd_seen && $urandom_range(0, 1) == 1) begin
                bus.i_rd_req  = 1'b0;
                bus.i_rd_addr = 20'($urandom);
                rd_seen = rd_grants;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            bus.i_rd_req  = 1'b1;
            bus.i_rd_addr = 20'($urandom);
            rd_seen = rd_grants;
        end
    endtask

    int   base;
    logic got;

    // NOTE: inputs change with blocking writes #1 after the rising edge, outputs are read on the falling edge.
    initial begin
        bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;
        repeat (2) @(negedge bclk);
        check("rst_addr", bus.o_SRAM_ADDR, 20'h0);
        check("rst_dq", bus.o_SRAM_DQ, 16'h0);
        check("rst_dq_oe", bus.o_SRAM_DQ_oe, 1'b0);
        check("rst_we_n", bus.o_SRAM_WE_N, 1'b1);
        check("rst_oe_n", bus.o_SRAM_OE_N, 1'b1);
        check("rst_ce_n", bus.o_SRAM_CE_N, 1'b1);
        check("rst_wr_ack", bus.o_wr_ack, 1'b0);
        check("rst_rd_valid", bus.o_rd_valid, 1'b0);
        check("rst_rd_data", bus.o_rd_data, 16'h0);
        check("rst_busy", bus.o_busy, 1'b0);
        @(posedge bclk); #1 rst_n = 1'b1;

        // Directed write; request dropped and address changed right after grant.
        @(posedge bclk); #1;
        wr_seen = wr_grants;
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h00010; bus.i_wr_data = 16'hBEEF;
        for (int i = 0; i < 20 && wr_grants == wr_seen; i++) begin @(posedge bclk); #1; end
        check("dir_wr_granted", wr_grants != wr_seen, 1'b1);
        bus.i_wr_req = 1'b0; bus.i_wr_addr = 20'hABCDE; bus.i_wr_data = 16'h1234;
        wr_seen = wr_grants;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge bclk); got = bus.o_wr_ack; end
        check("dir_wr_ack_seen", got, 1'b1);
        check("dir_wr_mem", sram[16], 16'hBEEF);

        // Both requesters held high across four operations.
        @(posedge bclk); #1;
        base = obs_q.size();
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h00020; bus.i_wr_data = 16'h5A5A;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 20'h00010;
        for (int i = 0; i < 200 && obs_q.size() < base + 4; i++) begin @(posedge bclk); #1; end
        bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
        wr_seen = wr_grants; rd_seen = rd_grants;
        check("tie_ops_done", obs_q.size() >= base + 4, 1'b1);
        for (int k = 0; k < 4; k++)
            check($sformatf("tie_grant%0d", k), obs_q[base + k], (RR && (k % 2 == 1)) ? CH_W : CH_R);
        repeat (20) @(posedge bclk);

        // Directed read of the word written above.
        #1;
        rd_seen = rd_grants;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 20'h00010;
        for (int i = 0; i < 20 && rd_grants == rd_seen; i++) begin @(posedge bclk); #1; end
        check("dir_rd_granted", rd_grants != rd_seen, 1'b1);
        bus.i_rd_req = 1'b0; bus.i_rd_addr = 20'h00033;
        rd_seen = rd_grants;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge bclk); got = bus.o_rd_valid; end
        check("dir_rd_valid_seen", got, 1'b1);
        check("dir_rd_data", bus.o_rd_data, 16'hBEEF);
        repeat (5) @(posedge bclk);

        // Reset asserted while WE_N is low.
        #1;
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h00030; bus.i_wr_data = 16'hC0DE;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge bclk); got = !bus.o_SRAM_WE_N; end
        check("rst_mid_saw_pulse", got, 1'b1);
        #1 rst_n = 1'b0;
        bus.i_wr_req = 1'b0;
        #1;
        check("rst_mid_we_n", bus.o_SRAM_WE_N, 1'b1);
        check("rst_mid_ce_n", bus.o_SRAM_CE_N, 1'b1);
        check("rst_mid_dq_oe", bus.o_SRAM_DQ_oe, 1'b0);
        check("rst_mid_wr_ack", bus.o_wr_ack, 1'b0);
        check("rst_mid_busy", bus.o_busy, 1'b0);
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h00031; bus.i_wr_data = 16'h7777;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 20'h00032;
        repeat (2) @(negedge bclk);
        @(posedge bclk); #1 rst_n = 1'b1;
        base = obs_q.size();
        for (int i = 0; i < 30 && obs_q.size() <= base; i++) begin @(posedge bclk); #1; end
        bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
        check("post_rst_first_grant", obs_q[base], RR ? CH_W : CH_R);
        repeat (20) @(posedge bclk);
        wr_seen = wr_grants; rd_seen = rd_grants;

        // Random requesters.
        repeat (3000) begin
            @(posedge bclk); #1;
            agent_step();
        end
        @(posedge bclk); #1;
        bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
        repeat (30) @(posedge bclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
